spi_burst_memory: RTL and testbench

Parametrised successor to the SPI register memory: an SPI slave (mode 0: sample MOSI on SCLK rise, drive MISO on SCLK fall) fronting a 2^ADDR_WIDTH × DATA_WIDTH register array. It sits between the board SPI pins and the `clk` domain. It adds configurable widths, input synchronisation, synchronous reset, an explicit MISO output enable, and optional burst transfers with address auto-increment while `cs_pin` stays low.

---
 rtl/spi_burst_memory_pkg.sv | 29 ++
 rtl/spi_burst_memory_if.sv | 37 +++
 rtl/spi_burst_memory_sync_edge.sv | 40 ++++
 rtl/spi_burst_memory.sv | 214 +++++++++++++++++++++
 tb/tb_spi_burst_memory.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_burst_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI burst memory:
//                FSM state encoding, command-bit values and a helper that
//                sizes the bit counter.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        CMD   = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } spi_state_e;

    localparam logic SPI_CMD_READ  = 1'b1;
    localparam logic SPI_CMD_WRITE = 1'b0;

    // Width needed to count 0 .. max_count-1 (never narrower than one bit)
    function automatic int spi_cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_burst_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_burst_memory_if
//  Description : Board-side SPI pins plus status LEDs of the burst memory.
//                The SPI master drives clock, select and data-in; the
//                memory returns data-out, its output enable and the LEDs.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_burst_memory_if;

    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin;
    logic       miso_oe;
    logic [3:0] leds;

    modport master (
        output sclk_pin,
        output cs_pin,
        output mosi_pin,
        input  miso_pin,
        input  miso_oe,
        input  leds
    );

    modport slave (
        input  sclk_pin,
        input  cs_pin,
        input  mosi_pin,
        output miso_pin,
        output miso_oe,
        output leds
    );

endinterface
`default_nettype wire

// File: rtl/spi_burst_memory_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchroniser for an asynchronous pin followed by
//                an edge register. Edge strobes are combinational from the
//                last two samples so the consumer acts one clk later.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic pin,
    output logic      level,
    output logic      rise,
    output logic      fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the synchroniser and remember the previous level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  =  level & ~r_prev;
    assign fall  = ~level &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_burst_memory.sv
`default_nettype none
// ============================================================================
//  Module      : spi_burst_memory
//  Description : Mode-0 SPI slave in front of a 2^ADDR_WIDTH x DATA_WIDTH
//                register array. Frame = address, command bit, then data
//                words; bursts auto-increment the address while CS is low.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_burst_memory
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit BURST_EN    = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    spi_burst_memory_if.slave bus
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = spi_cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] c_addr_last = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_WIDTH - 1);

    spi_state_e r_state, w_state_next;

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_unused_edges;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;

    logic [CNT_W-1:0]      r_bit_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_miso;
    logic                  r_miso_oe;
    logic [3:0]            r_leds;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic                  w_addr_done;
    logic                  w_data_done;
    logic                  w_mem_we;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (bus.sclk_pin),
        .level (w_sclk_level),
        .rise  (w_sclk_rise),
        .fall  (w_sclk_fall)
    );

    // CS resets high so a released board pin never looks like a new frame
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (bus.cs_pin),
        .level (w_cs_level),
        .rise  (w_cs_rise),
        .fall  (w_cs_fall)
    );

    // SCLK level and CS rise are not needed: CS high alone aborts a frame
    assign w_unused_edges = w_sclk_level ^ w_cs_rise;

    // MOSI takes the same number of stages as SCLK so it lines up with the edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_pin};
        end
    end

    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_rd_word   = r_mem[r_addr];
    assign w_wr_word   = {r_shift[DATA_WIDTH-2:0], w_mosi};
    assign w_addr_done = (r_bit_cnt == c_addr_last);
    assign w_data_done = (r_bit_cnt == c_data_last);
    assign w_mem_we    = !w_cs_level && (r_state == WRITE) && w_sclk_rise && w_data_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; CS high overrides every state
    always_comb begin
        w_state_next = r_state;
        if (w_cs_level) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) w_state_next = ADDR;
                end
                ADDR: begin
                    if (w_sclk_rise && w_addr_done) w_state_next = CMD;
                end
                CMD: begin
                    if (w_sclk_rise) begin
                        if (w_mosi == SPI_CMD_READ) begin
                            w_state_next = READ;
                        end else if (w_mosi == SPI_CMD_WRITE) begin
                            w_state_next = WRITE;
                        end
                    end
                end
                READ, WRITE: begin
                    if (w_sclk_rise && w_data_done && !BURST_EN) w_state_next = DONE;
                end
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Datapath: bit counter, address, shift register, MISO and LEDs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_addr    <= '0;
            r_shift   <= '0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_leds    <= 4'h0;
        end else if (w_cs_level) begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                end
                ADDR: begin
                    if (w_sclk_rise) begin
                        r_addr    <= {r_addr[ADDR_WIDTH-2:0], w_mosi};
                        r_bit_cnt <= w_addr_done ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                CMD: begin
                    if (w_sclk_rise) r_bit_cnt <= '0;
                end
                WRITE: begin
                    if (w_sclk_rise) begin
                        if (w_data_done) begin
                            r_bit_cnt <= '0;
                            r_addr    <= r_addr + 1'b1;
                            r_leds    <= w_wr_word[3:0];
                        end else begin
                            r_shift   <= w_wr_word;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_sclk_fall) begin
                        if (r_bit_cnt == '0) begin
                            r_shift   <= w_rd_word;
                            r_miso    <= w_rd_word[DATA_WIDTH-1];
                            r_miso_oe <= 1'b1;
                        end else begin
                            r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                            r_miso    <= r_shift[DATA_WIDTH-2];
                        end
                    end else if (w_sclk_rise) begin
                        if (w_data_done) begin
                            r_bit_cnt <= '0;
                            r_addr    <= r_addr + 1'b1;
                            // Leaving READ for DONE: MISO idles low, OE holds until CS
                            if (!BURST_EN) r_miso <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= w_wr_word;
        end
    end

    assign bus.miso_pin = r_miso;
    assign bus.miso_oe  = r_miso_oe;
    assign bus.leds     = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_burst_memory
//  Description : Directed bench for spi_burst_memory. Drives two instances
//                (default widths with bursts, and 4-bit address / 16-bit
//                data without bursts) from one bit-banged SPI master.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_burst_memory;

    localparam int H = 8;  // clk cycles per SCLK phase

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sclk  = 1'b0;
    logic mosi  = 1'b0;
    logic cs_a  = 1'b1;
    logic cs_b  = 1'b1;
    logic sel   = 1'b0;
    logic miso_sel;
    logic oe_sel;

    int checks = 0;
    int errors = 0;

    logic [31:0] rx;
    logic        oe_and, oe_or, hdr_oe;

    spi_burst_memory_if bus_a ();
    spi_burst_memory_if bus_b ();

    assign bus_a.sclk_pin = sclk;
    assign bus_a.mosi_pin = mosi;
    assign bus_a.cs_pin   = cs_a;
    assign bus_b.sclk_pin = sclk;
    assign bus_b.mosi_pin = mosi;
    assign bus_b.cs_pin   = cs_b;

    assign miso_sel = sel ? bus_b.miso_pin : bus_a.miso_pin;
    assign oe_sel   = sel ? bus_b.miso_oe  : bus_a.miso_oe;

    spi_burst_memory #(
        .ADDR_WIDTH  (7),
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2),
        .BURST_EN    (1'b1)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    spi_burst_memory #(
        .ADDR_WIDTH  (4),
        .DATA_WIDTH  (16),
        .SYNC_STAGES (2),
        .BURST_EN    (1'b0)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift n bits MSB first; MISO/OE sampled just before each rising SCLK
    task automatic xfer(input logic [31:0] val, input int n,
                        output logic [31:0] rxd, output logic oa, output logic oo);
        rxd = '0;
        oa  = 1'b1;
        oo  = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            repeat (H) @(negedge clk);
            rxd  = {rxd[30:0], miso_sel};
            oa   = oa & oe_sel;
            oo   = oo | oe_sel;
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start(input logic s);
        sel = s;
        if (s) cs_b = 1'b0;
        else   cs_a = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (H) @(negedge clk);
        cs_a = 1'b1;
        cs_b = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Address + command bit; reports whether OE was ever seen high
    task automatic header(input logic s, input int aw, input logic [31:0] addr,
                          input logic cmd, output logic oe_seen);
        logic [31:0] d;
        logic        a1, o1, a2, o2;
        frame_start(s);
        xfer(addr, aw, d, a1, o1);
        xfer({31'd0, cmd}, 1, d, a2, o2);
        oe_seen = o1 | o2;
    endtask

    task automatic spi_write(input logic s, input int aw, input logic [31:0] addr,
                             input int dw, input logic [31:0] data);
        logic [31:0] d;
        logic        a, o, h;
        header(s, aw, addr, 1'b0, h);
        xfer(data, dw, d, a, o);
        frame_end();
    endtask

    task automatic spi_read(input logic s, input int aw, input logic [31:0] addr,
                            input int dw, output logic [31:0] rxd,
                            output logic oa, output logic ho);
        logic o;
        header(s, aw, addr, 1'b1, ho);
        xfer(32'd0, dw, rxd, oa, o);
        frame_end();
    endtask

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("reset_miso_a", {31'd0, bus_a.miso_pin}, 32'd0);
        check("reset_oe_a",   {31'd0, bus_a.miso_oe},  32'd0);
        check("reset_leds_a", {28'd0, bus_a.leds},     32'd0);
        check("reset_oe_b",   {31'd0, bus_b.miso_oe},  32'd0);
        check("reset_leds_b", {28'd0, bus_b.leds},     32'd0);

        // Single write / read at top address
        spi_write(1'b0, 7, 32'h7F, 8, 32'hB1);
        check("leds_after_b1", {28'd0, bus_a.leds}, 32'h1);
        spi_read(1'b0, 7, 32'h7F, 8, rx, oe_and, hdr_oe);
        check("read_7f",        rx, 32'hB1);
        check("read_7f_oe",     {31'd0, oe_and}, 32'd1);
        check("read_7f_hdr_oe", {31'd0, hdr_oe}, 32'd0);
        check("oe_after_frame", {31'd0, bus_a.miso_oe},  32'd0);
        check("miso_idle",      {31'd0, bus_a.miso_pin}, 32'd0);

        // Second pattern
        spi_write(1'b0, 7, 32'h55, 8, 32'h92);
        check("leds_after_92", {28'd0, bus_a.leds}, 32'h2);
        spi_read(1'b0, 7, 32'h55, 8, rx, oe_and, hdr_oe);
        check("read_55",        rx, 32'h92);
        check("read_55_hdr_oe", {31'd0, hdr_oe}, 32'd0);
        check("read_55_oe_end", {31'd0, bus_a.miso_oe}, 32'd0);

        // Burst write with address wrap, then burst read back
        header(1'b0, 7, 32'h7E, 1'b0, hdr_oe);
        xfer(32'h11, 8, rx, oe_and, oe_or);
        xfer(32'h22, 8, rx, oe_and, oe_or);
        xfer(32'h33, 8, rx, oe_and, oe_or);
        frame_end();
        check("leds_after_burst", {28'd0, bus_a.leds}, 32'h3);
        header(1'b0, 7, 32'h7E, 1'b1, hdr_oe);
        xfer(32'd0, 24, rx, oe_and, oe_or);
        frame_end();
        check("burst_read",    rx, 32'h112233);
        check("burst_read_oe", {31'd0, oe_and}, 32'd1);
        spi_read(1'b0, 7, 32'h00, 8, rx, oe_and, hdr_oe);
        check("read_wrap_00", rx, 32'h33);
        spi_read(1'b0, 7, 32'h7F, 8, rx, oe_and, hdr_oe);
        check("read_burst_7f", rx, 32'h22);

        // Aborted write leaves memory and LEDs untouched
        spi_write(1'b0, 7, 32'h10, 8, 32'h5A);
        check("leds_after_5a", {28'd0, bus_a.leds}, 32'hA);
        header(1'b0, 7, 32'h10, 1'b0, hdr_oe);
        xfer(32'hF, 4, rx, oe_and, oe_or);
        frame_end();
        check("abort_oe",   {31'd0, bus_a.miso_oe}, 32'd0);
        check("abort_leds", {28'd0, bus_a.leds},    32'hA);
        spi_read(1'b0, 7, 32'h10, 8, rx, oe_and, hdr_oe);
        check("abort_read_10", rx, 32'h5A);

        // Reset in the middle of a read data phase
        header(1'b0, 7, 32'h55, 1'b1, hdr_oe);
        xfer(32'd0, 3, rx, oe_and, oe_or);
        repeat (H) @(negedge clk);
        check("pre_reset_oe",   {31'd0, bus_a.miso_oe},  32'd1);
        check("pre_reset_miso", {31'd0, bus_a.miso_pin}, 32'd1);
        reset = 1'b1;
        cs_a  = 1'b1;
        @(negedge clk);
        check("mid_reset_oe",   {31'd0, bus_a.miso_oe},  32'd0);
        check("mid_reset_miso", {31'd0, bus_a.miso_pin}, 32'd0);
        check("mid_reset_leds", {28'd0, bus_a.leds},     32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        spi_read(1'b0, 7, 32'h55, 8, rx, oe_and, hdr_oe);
        check("post_reset_read", rx, 32'h92);
        check("post_reset_oe",   {31'd0, oe_and}, 32'd1);

        // Wide data, no burst: trailing bits are ignored
        spi_write(1'b1, 4, 32'hB, 16, 32'h1234);
        check("b_leds_1234", {28'd0, bus_b.leds}, 32'h4);
        header(1'b1, 4, 32'hA, 1'b0, hdr_oe);
        xfer(32'hBEEF, 16, rx, oe_and, oe_or);
        xfer(32'hFF, 8, rx, oe_and, oe_or);
        frame_end();
        check("b_leds_beef", {28'd0, bus_b.leds}, 32'hF);
        spi_read(1'b1, 4, 32'hA, 24, rx, oe_and, hdr_oe);
        check("b_read_a",       {16'd0, rx[23:8]}, 32'hBEEF);
        check("b_done_miso",    {24'd0, rx[7:0]},  32'h0);
        check("b_read_oe",      {31'd0, oe_and},   32'd1);
        spi_read(1'b1, 4, 32'hB, 16, rx, oe_and, hdr_oe);
        check("b_read_b_intact", rx, 32'h1234);
        check("b_oe_end", {31'd0, bus_b.miso_oe}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
